sad_accum_min: RTL and testbench
================================

Name: sad_accum_min

Overview:
- Consumes the per-cycle 8-input row sums produced by the fractional-ME adder tree.
- Accumulates ROWS row sums into one candidate block SAD, over CAND_NUM candidates per search.
- Tracks the minimum SAD and its candidate index.
- Sits between the adder tree and the ME decision/MV output logic.

Parameters:
- IN_WIDTH, 11, width of incoming row sum (adder-tree output: 8-bit data + 3).
- ROWS, 8, row sums per candidate block (power of 2).
- ROW_CNT_W, 3, log2(ROWS).
- CAND_NUM, 9, candidates per search (half-pel: centre + 8 neighbours).
- IDX_WIDTH, 4, candidate index width (≥ ceil(log2(CAND_NUM))).
- SAD_WIDTH, 14, IN_WIDTH + ROW_CNT_W; accumulated SAD width.

Ports:
- clk  input  1  system clock, rising edge.
- rst_n  input  1  asynchronous active-low reset.
- start_i  input  1  one-cycle pulse: begin a new search (aborts any search in progress).
- valid_i  input  1  row_sum_i valid this cycle.
- row_sum_i  input  IN_WIDTH  unsigned row SAD from the adder tree.
- busy_o  output  1  high while a search is active.
- cand_valid_o  output  1  one-cycle pulse: cand_sad_o/cand_idx_o hold a completed candidate.
- cand_sad_o  output  SAD_WIDTH  SAD of the candidate just completed.
- cand_idx_o  output  IDX_WIDTH  index of the candidate just completed.
- best_sad_o  output  SAD_WIDTH  running minimum SAD.
- best_idx_o  output  IDX_WIDTH  index of the running minimum.
- done_o  output  1  one-cycle pulse: search complete, best_* final.

Behaviour:
- Reset (rst_n low, async):
  - FSM = IDLE; acc, row_cnt, cand_cnt = 0.
  - busy_o, cand_valid_o, done_o = 0.
  - cand_sad_o, cand_idx_o, best_idx_o = 0.
  - best_sad_o = all ones.
- FSM states are IDLE, ACC.
- IDLE:
  - valid_i is ignored.
  - start_i → ACC on the next edge: acc, row_cnt, cand_cnt cleared; best_sad_o = all ones; best_idx_o = 0; busy_o = 1.
- ACC, valid_i = 1, row_cnt < ROWS-1:
  - acc <= acc + row_sum_i; row_cnt++.
- ACC, valid_i = 1, row_cnt = ROWS-1 (last row):
  - sum = acc + row_sum_i.
  - cand_sad_o <= sum; cand_idx_o <= cand_cnt; cand_valid_o <= 1.
  - acc <= 0; row_cnt <= 0.
  - If sum < best_sad_o (strict): best_sad_o <= sum, best_idx_o <= cand_cnt. Ties keep the earlier index.
  - If cand_cnt = CAND_NUM-1: done_o <= 1, busy_o <= 0, FSM → IDLE, cand_cnt <= 0.
  - Else cand_cnt++.
- ACC, valid_i = 0: all state holds. Gaps of any length between rows or candidates are legal.
- Latency:
  - cand_valid_o is asserted exactly 1 cycle after the clock edge that sampled the last row.
  - best_* already reflect that candidate in the same cycle.
  - done_o coincides with the final cand_valid_o.
- cand_valid_o and done_o are single-cycle pulses. cand_sad_o, cand_idx_o and best_* hold until next updated or until start_i.
- Arithmetic:
  - Unsigned, no saturation needed: ROWS × (2^IN_WIDTH − 1) fits SAD_WIDTH.
  - Max value 8 × 2047 = 16376 < 16384.
  - acc is SAD_WIDTH wide.
- start_i while in ACC:
  - Same-cycle restart: counters and best_* re-initialise as from IDLE; FSM stays in ACC.
  - No cand_valid_o or done_o for the aborted search.
  - valid_i in the start_i cycle is ignored.
- start_i in the same cycle as a last-row valid_i: start_i wins. No cand_valid_o or done_o; fresh search begins.
- Reset mid-search: immediate return to reset values; no pulses emitted.

Test Plan:
- Single candidate, CAND_NUM overridden to 1: start, then 8 valid rows 1..8 back-to-back.
  → cand_sad_o = 36, cand_idx_o = 0, cand_valid_o and done_o pulse 1 cycle after the 8th row; best_sad_o = 36, best_idx_o = 0.
- Full search of 9 candidates, each with constant row value r = {50, 40, 45, 30, 60, 30, 70, 35, 31}.
  → candidate SADs 400, 320, 360, 240, 480, 240, 560, 280, 248.
  → best_sad_o = 240, best_idx_o = 3 (tie at index 5 does not replace).
  → done_o pulses once, with the 9th cand_valid_o.
- Maximum input: all rows = 2047 for every candidate.
  → every cand_sad_o = 16376 with no wrap; best_idx_o = 0.
- Random valid_i gaps (0–5 idle cycles) inserted into the full-search stimulus.
  → identical cand_sad_o sequence and final best_* as the gap-free run; row_cnt holds during gaps.
- start_i asserted after 3 candidates plus 4 rows, then a clean 9-candidate search of r = 10 each.
  → no done_o from the aborted run; fresh results cand_idx 0..8, best_sad_o = 80, best_idx_o = 0.
- rst_n pulled low mid-candidate.
  → all outputs at reset values asynchronously, best_sad_o = 3FFF.
  → after release, valid_i without start_i is ignored: no cand_valid_o.

Source files
------------

// File: rtl/sad_accum_min.sv
// Block-SAD accumulator over ROWS row sums per candidate,
// tracking the minimum SAD and its index across a search.
module sad_accum_min #(
  parameter int IN_WIDTH  = 11,
  parameter int ROWS      = 8,
  parameter int ROW_CNT_W = 3,
  parameter int CAND_NUM  = 9,
  parameter int IDX_WIDTH = 4,
  parameter int SAD_WIDTH = 14
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start_i,
  input  logic                 valid_i,
  input  logic [IN_WIDTH-1:0]  row_sum_i,
  output logic                 busy_o,
  output logic                 cand_valid_o,
  output logic [SAD_WIDTH-1:0] cand_sad_o,
  output logic [IDX_WIDTH-1:0] cand_idx_o,
  output logic [SAD_WIDTH-1:0] best_sad_o,
  output logic [IDX_WIDTH-1:0] best_idx_o,
  output logic                 done_o
);

  typedef enum logic {IDLE, ACC} state_t;

  state_t               state;
  logic [SAD_WIDTH-1:0] acc;
  logic [ROW_CNT_W-1:0] row_cnt;
  logic [IDX_WIDTH-1:0] cand_cnt;

  logic [SAD_WIDTH-1:0] sum;
  logic                 take;
  logic                 last_row;
  logic                 last_cand;

  always_comb begin
    sum       = acc + SAD_WIDTH'(row_sum_i);
    take      = (state == ACC) && valid_i && !start_i;
    last_row  = (row_cnt == ROW_CNT_W'(ROWS - 1));
    last_cand = (cand_cnt == IDX_WIDTH'(CAND_NUM - 1));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      acc          <= '0;
      row_cnt      <= '0;
      cand_cnt     <= '0;
      busy_o       <= 1'b0;
      cand_valid_o <= 1'b0;
      done_o       <= 1'b0;
      cand_sad_o   <= '0;
      cand_idx_o   <= '0;
      best_sad_o   <= '1;
      best_idx_o   <= '0;
    end else begin
      cand_valid_o <= 1'b0;
      done_o       <= 1'b0;
      // start_i outranks any row sampled in the same cycle
      unique case (1'b1)
        start_i: begin
          state      <= ACC;
          acc        <= '0;
          row_cnt    <= '0;
          cand_cnt   <= '0;
          busy_o     <= 1'b1;
          cand_sad_o <= '0;
          cand_idx_o <= '0;
          best_sad_o <= '1;
          best_idx_o <= '0;
        end
        (take && !last_row): begin
          acc     <= sum;
          row_cnt <= row_cnt + 1'b1;
        end
        (take && last_row): begin
          acc          <= '0;
          row_cnt      <= '0;
          cand_sad_o   <= sum;
          cand_idx_o   <= cand_cnt;
          cand_valid_o <= 1'b1;
          if (sum < best_sad_o) begin
            best_sad_o <= sum;
            best_idx_o <= cand_cnt;
          end
          if (last_cand) begin
            done_o   <= 1'b1;
            busy_o   <= 1'b0;
            state    <= IDLE;
            cand_cnt <= '0;
          end else begin
            cand_cnt <= cand_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_sad_accum_min.sv
// Randomised scoreboard bench for sad_accum_min.
// Expected candidate events are queued by stimulus, popped by a monitor.
module tb_sad_accum_min;

  localparam int IW = 11;
  localparam int SW = 14;
  localparam int XW = 4;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start_i = 1'b0;
  logic          valid_i = 1'b0;
  logic [IW-1:0] row_sum_i = '0;
  logic          busy_o, cand_valid_o, done_o;
  logic [SW-1:0] cand_sad_o, best_sad_o;
  logic [XW-1:0] cand_idx_o, best_idx_o;

  logic          s1 = 1'b0;
  logic          v1 = 1'b0;
  logic [IW-1:0] r1 = '0;
  logic          busy1, cv1, done1;
  logic [SW-1:0] csad1, bsad1;
  logic [XW-1:0] cidx1, bidx1;

  always #5 clk = ~clk;

  sad_accum_min dut (
    .clk(clk), .rst_n(rst_n), .start_i(start_i),
    .valid_i(valid_i), .row_sum_i(row_sum_i),
    .busy_o(busy_o), .cand_valid_o(cand_valid_o),
    .cand_sad_o(cand_sad_o), .cand_idx_o(cand_idx_o),
    .best_sad_o(best_sad_o), .best_idx_o(best_idx_o),
    .done_o(done_o)
  );

  sad_accum_min #(.CAND_NUM(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start_i(s1),
    .valid_i(v1), .row_sum_i(r1),
    .busy_o(busy1), .cand_valid_o(cv1),
    .cand_sad_o(csad1), .cand_idx_o(cidx1),
    .best_sad_o(bsad1), .best_idx_o(bidx1),
    .done_o(done1)
  );

  typedef struct {
    int sad;
    int idx;
    int bsad;
    int bidx;
    int done;
  } exp_t;

  exp_t sbq[$];
  int   total = 0;
  int   bad = 0;
  int   rows[9][8];
  int   ref_best;
  int   ref_bidx;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Monitor: every candidate pulse must match the oldest queued entry
  always @(negedge clk) begin
    exp_t e;
    if (rst_n) begin
      if (cand_valid_o) begin
        if (sbq.size() == 0) begin
          total++;
          bad++;
          $display("FAIL unexpected_cand: got idx %0d expected none",
                   cand_idx_o);
        end else begin
          e = sbq.pop_front();
          chk("cand_sad", 32'(cand_sad_o), e.sad);
          chk("cand_idx", 32'(cand_idx_o), e.idx);
          chk("best_sad", 32'(best_sad_o), e.bsad);
          chk("best_idx", 32'(best_idx_o), e.bidx);
          chk("done", 32'(done_o), e.done);
        end
      end else if (done_o) begin
        total++;
        bad++;
        $display("FAIL lone_done: got 1 expected 0");
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_start(input logic v);
    start_i   = 1'b1;
    valid_i   = v;
    row_sum_i = 11'd123;
    tick();
    start_i = 1'b0;
    valid_i = 1'b0;
  endtask

  task automatic send_row(input int v, input int gap);
    valid_i = 1'b0;
    repeat (gap) tick();
    valid_i   = 1'b1;
    row_sum_i = IW'(v);
    tick();
    valid_i = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sbq.size() != 0 && n < 20) begin
      tick();
      n++;
    end
    total++;
    if (sbq.size() != 0) begin
      bad++;
      $display("FAIL drain: got %0d pending expected 0", sbq.size());
      sbq.delete();
    end
  endtask

  // Sends rows of the current table; stops after nrows rows (72 = full)
  task automatic run_search(input int maxgap, input int nrows,
                            input logic start_valid);
    int sent = 0;
    int sad;
    exp_t e;
    pulse_start(start_valid);
    chk("busy_after_start", 32'(busy_o), 1);
    ref_best = 16383;
    ref_bidx = 0;
    for (int c = 0; c < 9; c++) begin
      sad = 0;
      for (int r = 0; r < 8; r++) sad += rows[c][r];
      for (int r = 0; r < 8; r++) begin
        if (sent == nrows) return;
        if (r == 7) begin
          if (sad < ref_best) begin
            ref_best = sad;
            ref_bidx = c;
          end
          e.sad  = sad;
          e.idx  = c;
          e.bsad = ref_best;
          e.bidx = ref_bidx;
          e.done = (c == 8) ? 1 : 0;
          sbq.push_back(e);
        end
        send_row(rows[c][r], (maxgap > 0) ? $urandom_range(0, maxgap) : 0);
        sent++;
      end
    end
  endtask

  task automatic finish_check(input string tag);
    drain();
    chk({tag, "_busy"}, 32'(busy_o), 0);
    chk({tag, "_best_sad"}, 32'(best_sad_o), ref_best);
    chk({tag, "_best_idx"}, 32'(best_idx_o), ref_bidx);
  endtask

  task automatic fill_const(input int v0, input int v1_, input int v2,
                            input int v3, input int v4, input int v5,
                            input int v6, input int v7, input int v8);
    int k[9];
    k = '{v0, v1_, v2, v3, v4, v5, v6, v7, v8};
    for (int c = 0; c < 9; c++)
      for (int r = 0; r < 8; r++) rows[c][r] = k[c];
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
    chk("rst_busy", 32'(busy_o), 0);
    chk("rst_best_sad", 32'(best_sad_o), 16383);
    chk("rst_best_idx", 32'(best_idx_o), 0);
    chk("rst_cand_sad", 32'(cand_sad_o), 0);
    chk("rst_done", 32'(done_o), 0);

    // Single-candidate instance: rows 1..8
    s1 = 1'b1;
    tick();
    s1 = 1'b0;
    for (int i = 1; i <= 8; i++) begin
      v1 = 1'b1;
      r1 = IW'(i);
      tick();
    end
    v1 = 1'b0;
    chk("one_cv", 32'(cv1), 1);
    chk("one_done", 32'(done1), 1);
    chk("one_sad", 32'(csad1), 36);
    chk("one_idx", 32'(cidx1), 0);
    chk("one_best", 32'(bsad1), 36);
    chk("one_bidx", 32'(bidx1), 0);
    tick();
    chk("one_cv_pulse", 32'(cv1), 0);
    chk("one_busy", 32'(busy1), 0);

    fill_const(50, 40, 45, 30, 60, 30, 70, 35, 31);
    run_search(0, 72, 1'b0);
    finish_check("full");
    chk("full_best_fixed", 32'(best_sad_o), 240);

    fill_const(2047, 2047, 2047, 2047, 2047, 2047, 2047, 2047, 2047);
    run_search(0, 72, 1'b0);
    finish_check("max");

    fill_const(50, 40, 45, 30, 60, 30, 70, 35, 31);
    run_search(5, 72, 1'b0);
    finish_check("gaps");

    for (int t = 0; t < 3; t++) begin
      for (int c = 0; c < 9; c++)
        for (int r = 0; r < 8; r++) rows[c][r] = $urandom_range(0, 2047);
      run_search(t * 2, 72, 1'b0);
      finish_check("rand");
    end

    // Abort after 3 candidates + 4 rows, restart with valid in start cycle
    fill_const(99, 98, 97, 96, 95, 94, 93, 92, 91);
    run_search(0, 28, 1'b0);
    drain();
    fill_const(10, 10, 10, 10, 10, 10, 10, 10, 10);
    run_search(1, 72, 1'b1);
    finish_check("abort");
    chk("abort_best_fixed", 32'(best_sad_o), 80);

    // Reset mid-candidate
    fill_const(100, 100, 100, 100, 100, 100, 100, 100, 100);
    run_search(0, 13, 1'b0);
    drain();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_busy", 32'(busy_o), 0);
    chk("mid_rst_cv", 32'(cand_valid_o), 0);
    chk("mid_rst_done", 32'(done_o), 0);
    chk("mid_rst_cand_sad", 32'(cand_sad_o), 0);
    chk("mid_rst_cand_idx", 32'(cand_idx_o), 0);
    chk("mid_rst_best_sad", 32'(best_sad_o), 16383);
    chk("mid_rst_best_idx", 32'(best_idx_o), 0);
    tick();
    #2 rst_n = 1'b1;
    tick();
    for (int r = 0; r < 16; r++) send_row(7, 0);
    tick();
    chk("idle_ignore_busy", 32'(busy_o), 0);
    chk("idle_ignore_sad", 32'(cand_sad_o), 0);
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
